// File: rtl/rbus_pkg.sv
// Shared widths, src_req bit fields and the held-request record for the rbus request arbiter.
package rbus_pkg;

    localparam int RBUS_ADDR_W = 37;
    localparam int RBUS_REQ_W  = 10;
    localparam int RBUS_TAG_W  = 3;

    localparam int SRCREQ_CORE_HI = 9;
    localparam int SRCREQ_CORE_LO = 5;
    localparam int SRCREQ_IDX_HI  = 4;
    localparam int SRCREQ_IDX_LO  = 3;
    localparam int SRCREQ_TAG_HI  = 2;
    localparam int SRCREQ_TAG_LO  = 0;

    typedef struct packed {
        logic [RBUS_ADDR_W-1:0] addr;
        logic                   excl;
        logic [1:0]             idx;
        logic [RBUS_TAG_W-1:0]  tag;
    } rbus_hold_t;

    function automatic logic [RBUS_REQ_W-1:0] src_req_pack(input logic [4:0] core,
                                                           input logic [1:0] idx,
                                                           input logic [RBUS_TAG_W-1:0] tag);
        return {core, idx, tag};
    endfunction

endpackage

// File: rtl/rbus_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig_i at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] elig_i,
    input  logic [1:0]   ptr_i,
    output logic [N-1:0] gnt_o,
    output logic         vld_o,
    output logic [1:0]   idx_o
);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        vld_o = 1'b0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && elig_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = 2'(j);
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/rbus_req_arbiter.sv
// Round-robin arbiter for the outbound rbus with per-requester credits and reply routing.
// Optional statistics ports are enabled by defining RBUS_ARB_STATS_EN.
module rbus_req_arbiter
    import rbus_pkg::*;
#(
    parameter int         NREQ    = 4,
    parameter logic [4:0] CORE_ID = 5'd0,
    parameter int         MAX_OUT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_en,
    input  logic [NREQ*RBUS_ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0]             req_excl,
    input  logic [NREQ*RBUS_TAG_W-1:0]  req_tag,
    output logic [NREQ-1:0]             req_gnt,
    output logic                        rbusOut_want,
    input  logic                        rbusOut_can,
    output logic [RBUS_ADDR_W-1:0]      rbusOut_address,
    output logic [RBUS_REQ_W-1:0]       rbusOut_src_req,
    output logic                        rbusOut_code,
    input  logic                        rbusDIn_used,
    input  logic                        rbusDIn_second,
    input  logic [RBUS_REQ_W-1:0]       rbusDIn_dst_req,
    output logic [NREQ-1:0]             rpl_en,
    output logic [RBUS_TAG_W-1:0]       rpl_tag,
    output logic                        rpl_second,
    output logic [NREQ*3-1:0]           credit_cnt,
    output logic                        proto_err
`ifdef RBUS_ARB_STATS_EN
    ,
    output logic [31:0]                 stat_grants,
    output logic [31:0]                 stat_stall
`endif
);

    logic             want_q, want_d;
    rbus_hold_t       hold_q, hold_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       credit_q [NREQ];
    logic [2:0]       credit_d [NREQ];
    logic             err_q, err_d;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  pick_gnt;
    logic             pick_vld;
    logic [1:0]       pick_idx;
    logic             load;
    logic             accept;

    logic             core_hit;
    logic [1:0]       rpl_idx;
    logic [NREQ-1:0]  rls;
    logic             idx_bad;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_en[i] && (credit_q[i] < 3'(MAX_OUT));
        end
    end

    rr_pick #(.N(NREQ)) u_pick (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    assign accept  = want_q & rbusOut_can;
    // A grant can only land when the holding register is empty or draining this cycle.
    assign load    = rst & pick_vld & (~want_q | rbusOut_can);
    assign req_gnt = load ? pick_gnt : '0;

    assign core_hit   = rst & rbusDIn_used &
                        (rbusDIn_dst_req[SRCREQ_CORE_HI:SRCREQ_CORE_LO] == CORE_ID);
    assign rpl_idx    = rbusDIn_dst_req[SRCREQ_IDX_HI:SRCREQ_IDX_LO];
    assign idx_bad    = core_hit & (int'(rpl_idx) >= NREQ);
    assign rpl_tag    = rbusDIn_dst_req[SRCREQ_TAG_HI:SRCREQ_TAG_LO];
    assign rpl_second = rbusDIn_second;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rpl_en[i] = core_hit & (rpl_idx == 2'(i));
            rls[i]    = rpl_en[i] & rbusDIn_second;
        end
    end

    always_comb begin
        logic underflow;
        underflow = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            credit_d[i] = credit_q[i];
            if (req_gnt[i] && !rls[i]) begin
                credit_d[i] = credit_q[i] + 3'd1;
            end else if (!req_gnt[i] && rls[i]) begin
                if (credit_q[i] == 3'd0) begin
                    underflow = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] - 3'd1;
                end
            end
        end
        err_d = err_q | underflow | idx_bad;
    end

    always_comb begin
        want_d = want_q;
        hold_d = hold_q;
        ptr_d  = ptr_q;
        if (load) begin
            want_d      = 1'b1;
            hold_d.addr = req_addr[int'(pick_idx)*RBUS_ADDR_W +: RBUS_ADDR_W];
            hold_d.excl = req_excl[pick_idx];
            hold_d.idx  = pick_idx;
            hold_d.tag  = req_tag[int'(pick_idx)*RBUS_TAG_W +: RBUS_TAG_W];
            ptr_d       = 2'((int'(pick_idx) + 1) % NREQ);
        end else if (accept) begin
            want_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            want_q <= 1'b0;
            // excl resets high so the exported code bit reads 0 while in reset.
            hold_q <= '{addr: '0, excl: 1'b1, idx: '0, tag: '0};
            ptr_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            want_q <= want_d;
            hold_q <= hold_d;
            ptr_q  <= ptr_d;
            err_q  <= err_d;
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            credit_cnt[i*3 +: 3] = credit_q[i];
        end
    end

    assign rbusOut_want    = want_q;
    assign rbusOut_address = hold_q.addr;
    assign rbusOut_src_req = src_req_pack(CORE_ID, hold_q.idx, hold_q.tag) &
                             {RBUS_REQ_W{want_q}};
    assign rbusOut_code    = ~hold_q.excl;
    assign proto_err       = err_q;

`ifdef RBUS_ARB_STATS_EN
    logic [31:0] stat_grants_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_grants_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (accept) begin
                stat_grants_q <= stat_grants_q + 32'd1;
            end
            if (want_q && !rbusOut_can) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_rbus_req_arbiter.sv
// Table-driven bench for rbus_req_arbiter with a scoreboard of granted requests.
module tb_rbus_req_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_en;
    logic [147:0]  req_addr;
    logic [3:0]    req_excl;
    logic [11:0]   req_tag;
    logic [3:0]    req_gnt;
    logic          rbusOut_want;
    logic          rbusOut_can;
    logic [36:0]   rbusOut_address;
    logic [9:0]    rbusOut_src_req;
    logic          rbusOut_code;
    logic          rbusDIn_used;
    logic          rbusDIn_second;
    logic [9:0]    rbusDIn_dst_req;
    logic [3:0]    rpl_en;
    logic [2:0]    rpl_tag;
    logic          rpl_second;
    logic [11:0]   credit_cnt;
    logic          proto_err;

    always #5 clk = ~clk;

    rbus_req_arbiter #(.NREQ(4), .CORE_ID(5'd0), .MAX_OUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_en          (req_en),
        .req_addr        (req_addr),
        .req_excl        (req_excl),
        .req_tag         (req_tag),
        .req_gnt         (req_gnt),
        .rbusOut_want    (rbusOut_want),
        .rbusOut_can     (rbusOut_can),
        .rbusOut_address (rbusOut_address),
        .rbusOut_src_req (rbusOut_src_req),
        .rbusOut_code    (rbusOut_code),
        .rbusDIn_used    (rbusDIn_used),
        .rbusDIn_second  (rbusDIn_second),
        .rbusDIn_dst_req (rbusDIn_dst_req),
        .rpl_en          (rpl_en),
        .rpl_tag         (rpl_tag),
        .rpl_second      (rpl_second),
        .credit_cnt      (credit_cnt),
        .proto_err       (proto_err)
    );

    typedef struct {
        logic [3:0]  en;
        logic        can;
        logic        used;
        logic        second;
        logic [9:0]  dst;
        logic [3:0]  x_gnt;
        logic        x_want;
        logic [3:0]  x_rpl;
        logic [11:0] x_cred;
        logic        x_err;
    } vec_t;

    typedef struct {
        logic [36:0] addr;
        logic [9:0]  src;
        logic        code;
    } exp_t;

    vec_t        vecs_a[$];
    vec_t        vecs_b[$];
    exp_t        sb[$];
    logic [36:0] r_addr [4];
    logic [2:0]  r_tag  [4];
    logic        r_excl [4];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] en, input logic can, input logic used,
                                input logic second, input logic [9:0] dst,
                                input logic [3:0] xg, input logic xw, input logic [3:0] xr,
                                input logic [11:0] xc, input logic xe);
        vec_t v;
        v.en = en; v.can = can; v.used = used; v.second = second; v.dst = dst;
        v.x_gnt = xg; v.x_want = xw; v.x_rpl = xr; v.x_cred = xc; v.x_err = xe;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int n);
        string nm;
        exp_t  e;
        req_en          = v.en;
        rbusOut_can     = v.can;
        rbusDIn_used    = v.used;
        rbusDIn_second  = v.second;
        rbusDIn_dst_req = v.dst;
        #4;
        nm = $sformatf("v%0d", n);
        chk({nm, ".gnt"},  64'(req_gnt),      64'(v.x_gnt));
        chk({nm, ".want"}, 64'(rbusOut_want), 64'(v.x_want));
        chk({nm, ".rpl"},  64'(rpl_en),       64'(v.x_rpl));
        chk({nm, ".cred"}, 64'(credit_cnt),   64'(v.x_cred));
        chk({nm, ".err"},  64'(proto_err),    64'(v.x_err));
        if (v.x_rpl != 4'd0) begin
            chk({nm, ".rtag"}, 64'(rpl_tag),    64'(v.dst[2:0]));
            chk({nm, ".rsec"}, 64'(rpl_second), 64'(v.second));
        end
        if (rbusOut_want) begin
            if (sb.size() == 0) begin
                chk({nm, ".sb_empty"}, 64'(1), 64'(0));
            end else begin
                chk({nm, ".addr"}, 64'(rbusOut_address), 64'(sb[0].addr));
                chk({nm, ".src"},  64'(rbusOut_src_req), 64'(sb[0].src));
                chk({nm, ".code"}, 64'(rbusOut_code),    64'(sb[0].code));
                if (v.can) void'(sb.pop_front());
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (v.x_gnt[i]) begin
                e.addr = r_addr[i];
                e.src  = {5'd0, 2'(i), r_tag[i]};
                e.code = ~r_excl[i];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached got running expected finished");
        $fatal(1);
    end

    initial begin
        r_addr[0] = 37'h0_0ABC_0100; r_addr[1] = 37'h1_0000_2040;
        r_addr[2] = 37'h0_7654_3200; r_addr[3] = 37'h1_2345_6780;
        for (int i = 0; i < 4; i++) begin
            r_tag[i]  = 3'(i + 4);
            r_excl[i] = 1'(i % 2);
        end
        req_addr = {r_addr[3], r_addr[2], r_addr[1], r_addr[0]};
        req_tag  = {r_tag[3], r_tag[2], r_tag[1], r_tag[0]};
        req_excl = {r_excl[3], r_excl[2], r_excl[1], r_excl[0]};

        // round robin, stall, replies, foreign core, underflow error
        vecs_a.push_back(mk(4'hF, 1, 0, 0, 10'h000, 4'b0001, 0, 4'b0000, 12'h000, 0));
        vecs_a.push_back(mk(4'hF, 1, 0, 0, 10'h000, 4'b0010, 1, 4'b0000, 12'h001, 0));
        vecs_a.push_back(mk(4'hF, 1, 0, 0, 10'h000, 4'b0100, 1, 4'b0000, 12'h009, 0));
        vecs_a.push_back(mk(4'hF, 1, 0, 0, 10'h000, 4'b1000, 1, 4'b0000, 12'h049, 0));
        vecs_a.push_back(mk(4'hF, 0, 0, 0, 10'h000, 4'b0000, 1, 4'b0000, 12'h249, 0));
        vecs_a.push_back(mk(4'hF, 0, 0, 0, 10'h000, 4'b0000, 1, 4'b0000, 12'h249, 0));
        vecs_a.push_back(mk(4'hF, 0, 0, 0, 10'h000, 4'b0000, 1, 4'b0000, 12'h249, 0));
        vecs_a.push_back(mk(4'hF, 1, 0, 0, 10'h000, 4'b0001, 1, 4'b0000, 12'h249, 0));
        vecs_a.push_back(mk(4'h0, 1, 0, 0, 10'h000, 4'b0000, 1, 4'b0000, 12'h24A, 0));
        vecs_a.push_back(mk(4'h0, 1, 1, 0, 10'h01E, 4'b0000, 0, 4'b1000, 12'h24A, 0));
        vecs_a.push_back(mk(4'h0, 1, 1, 1, 10'h01E, 4'b0000, 0, 4'b1000, 12'h24A, 0));
        vecs_a.push_back(mk(4'h0, 1, 1, 1, 10'h031, 4'b0000, 0, 4'b0000, 12'h04A, 0));
        vecs_a.push_back(mk(4'h0, 1, 1, 1, 10'h018, 4'b0000, 0, 4'b1000, 12'h04A, 0));
        vecs_a.push_back(mk(4'h0, 1, 0, 0, 10'h000, 4'b0000, 0, 4'b0000, 12'h04A, 1));
        vecs_a.push_back(mk(4'h1, 0, 0, 0, 10'h000, 4'b0001, 0, 4'b0000, 12'h04A, 1));
        vecs_a.push_back(mk(4'h0, 0, 0, 0, 10'h000, 4'b0000, 1, 4'b0000, 12'h04B, 1));

        // credit limit on requester 1, then simultaneous grant and release on requester 2
        vecs_b.push_back(mk(4'h2, 1, 0, 0, 10'h000, 4'b0010, 0, 4'b0000, 12'h000, 0));
        vecs_b.push_back(mk(4'h2, 1, 0, 0, 10'h000, 4'b0010, 1, 4'b0000, 12'h008, 0));
        vecs_b.push_back(mk(4'h2, 1, 0, 0, 10'h000, 4'b0010, 1, 4'b0000, 12'h010, 0));
        vecs_b.push_back(mk(4'h2, 1, 0, 0, 10'h000, 4'b0010, 1, 4'b0000, 12'h018, 0));
        vecs_b.push_back(mk(4'h2, 1, 0, 0, 10'h000, 4'b0000, 1, 4'b0000, 12'h020, 0));
        vecs_b.push_back(mk(4'h2, 1, 1, 1, 10'h00D, 4'b0000, 0, 4'b0010, 12'h020, 0));
        vecs_b.push_back(mk(4'h2, 1, 0, 0, 10'h000, 4'b0010, 0, 4'b0000, 12'h018, 0));
        vecs_b.push_back(mk(4'h0, 1, 0, 0, 10'h000, 4'b0000, 1, 4'b0000, 12'h020, 0));
        vecs_b.push_back(mk(4'h4, 1, 0, 0, 10'h000, 4'b0100, 0, 4'b0000, 12'h020, 0));
        vecs_b.push_back(mk(4'h4, 1, 1, 1, 10'h010, 4'b0100, 1, 4'b0100, 12'h060, 0));
        vecs_b.push_back(mk(4'h0, 1, 0, 0, 10'h000, 4'b0000, 1, 4'b0000, 12'h060, 0));
        vecs_b.push_back(mk(4'h0, 1, 0, 0, 10'h000, 4'b0000, 0, 4'b0000, 12'h060, 0));

        // power-on reset held two cycles with all requesters asking
        rst = 1'b0; req_en = 4'hF; rbusOut_can = 1'b1;
        rbusDIn_used = 1'b0; rbusDIn_second = 1'b0; rbusDIn_dst_req = '0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            #4;
            chk("rst.want", 64'(rbusOut_want), 64'(0));
            chk("rst.gnt",  64'(req_gnt),      64'(0));
            chk("rst.cred", 64'(credit_cnt),   64'(0));
            chk("rst.err",  64'(proto_err),    64'(0));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        for (int n = 0; n < vecs_a.size(); n++) apply(vecs_a[n], n);

        // reset while a request is held; a reply during reset must be ignored
        rst = 1'b0; req_en = 4'hF; rbusOut_can = 1'b0;
        rbusDIn_used = 1'b1; rbusDIn_second = 1'b1; rbusDIn_dst_req = 10'h000;
        #4;
        chk("mrst.gnt", 64'(req_gnt), 64'(0));
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b1; req_en = 4'h0; rbusDIn_used = 1'b0; rbusDIn_second = 1'b0;
        #4;
        chk("mrst.want", 64'(rbusOut_want), 64'(0));
        chk("mrst.cred", 64'(credit_cnt),   64'(0));
        chk("mrst.err",  64'(proto_err),    64'(0));
        chk("mrst.code", 64'(rbusOut_code), 64'(0));
        @(posedge clk);
        #1;
        for (int n = 0; n < vecs_b.size(); n++) apply(vecs_b[n], 100 + n);

        chk("sb.drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
